// File: rtl/mdc_commutator_if.sv
// rtl/mdc_commutator_if.sv - sample-pair bus for the MDC commutator stage (in_flush present with MDC_COMMUTATOR_FLUSH_EN).
interface mdc_commutator_if #(
   parameter int nb = 16
);
   logic          in_valid;
   logic          in_sof;
   logic [nb-1:0] in_a;
   logic [nb-1:0] in_b;
`ifdef MDC_COMMUTATOR_FLUSH_EN
   logic          in_flush;
`endif
   logic          out_valid;
   logic          out_sof;
   logic [nb-1:0] out_a;
   logic [nb-1:0] out_b;

   modport master (
      output in_valid, in_sof, in_a, in_b,
`ifdef MDC_COMMUTATOR_FLUSH_EN
      output in_flush,
`endif
      input  out_valid, out_sof, out_a, out_b
   );

   modport slave (
      input  in_valid, in_sof, in_a, in_b,
`ifdef MDC_COMMUTATOR_FLUSH_EN
      input  in_flush,
`endif
      output out_valid, out_sof, out_a, out_b
   );
endinterface

// File: rtl/mdc_commutator.sv
// rtl/mdc_commutator.sv - radix-2 MDC commutator: re-pairs (x[n],y[n]) into (x[n],x[n+D]) and (y[n],y[n+D]).
// MDC_COMMUTATOR_FLUSH_EN adds in_flush bubbles that drain the last depth pairs of a stream.
module mdc_commutator #(
   parameter int nb    = 16,
   parameter int depth = 4
) (
   input  logic            clk,
   input  logic            rst,
   mdc_commutator_if.slave bus
);
   localparam int CW = (depth > 1) ? $clog2(2 * depth) : 1;
   localparam int FW = $clog2(depth + 2);
   localparam int PW = $clog2(depth + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * depth - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(depth);
   localparam logic [FW-1:0] F_SOF    = FW'(depth);
   localparam logic [FW-1:0] F_SAT    = FW'(depth + 1);
   localparam logic [PW-1:0] P_FULL   = PW'(depth);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] fidx_q, fidx_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [nb-1:0] bline_q [depth];
   logic [nb-1:0] bline_d [depth];
   logic [nb-1:0] pline_q [depth];
   logic [nb-1:0] pline_d [depth];
   logic          out_valid_q, out_valid_d;
   logic          out_sof_q, out_sof_d;
   logic [nb-1:0] out_a_q, out_a_d;
   logic [nb-1:0] out_b_q, out_b_d;

   logic          sof_in, accept, primed, drain_ok, valid_now, sel;
   logic [CW-1:0] idx;
   logic [FW-1:0] fidx;
   logic [nb-1:0] sa, sb, bd, p, q;

`ifdef MDC_COMMUTATOR_FLUSH_EN
   logic [PW-1:0] drain_q, drain_d;
   logic          bubble;
`endif

   always_comb begin
      // pcnt_q counts from the first in_sof, so nonzero means a frame has started
      sof_in   = bus.in_valid & bus.in_sof;
      accept   = bus.in_valid & (sof_in | (pcnt_q != '0));
      sa       = bus.in_a;
      sb       = bus.in_b;
      drain_ok = 1'b1;
`ifdef MDC_COMMUTATOR_FLUSH_EN
      bubble  = ~bus.in_valid & bus.in_flush & (pcnt_q != '0);
      drain_d = drain_q;
      if (bubble) begin
         accept   = 1'b1;
         sof_in   = 1'b0;
         sa       = '0;
         sb       = '0;
         drain_ok = (drain_q != P_FULL);
         if (drain_ok) drain_d = drain_q + PW'(1);
      end else if (bus.in_valid) begin
         drain_d = '0;
      end
`endif
      idx       = sof_in ? '0 : cnt_q;
      fidx      = sof_in ? '0 : fidx_q;
      sel       = (idx >= CNT_HALF);
      bd        = bline_q[depth-1];
      p         = sel ? bd : sa;
      q         = sel ? sa : bd;
      primed    = (pcnt_q == P_FULL);
      valid_now = accept & primed & drain_ok;

      cnt_d       = cnt_q;
      fidx_d      = fidx_q;
      pcnt_d      = pcnt_q;
      bline_d     = bline_q;
      pline_d     = pline_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      if (accept) begin
         cnt_d      = (idx == CNT_LAST) ? '0 : idx + CW'(1);
         fidx_d     = (fidx == F_SAT) ? F_SAT : fidx + FW'(1);
         pcnt_d     = primed ? pcnt_q : pcnt_q + PW'(1);
         bline_d[0] = sb;
         pline_d[0] = p;
         for (int i = 1; i < depth; i++) begin
            bline_d[i] = bline_q[i-1];
            pline_d[i] = pline_q[i-1];
         end
         out_a_d     = pline_q[depth-1];
         out_b_d     = q;
         out_valid_d = valid_now;
         out_sof_d   = valid_now & (fidx == F_SOF);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         fidx_q      <= '0;
         pcnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         for (int i = 0; i < depth; i++) begin
            bline_q[i] <= '0;
            pline_q[i] <= '0;
         end
`ifdef MDC_COMMUTATOR_FLUSH_EN
         drain_q <= '0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         fidx_q      <= fidx_d;
         pcnt_q      <= pcnt_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         bline_q     <= bline_d;
         pline_q     <= pline_d;
`ifdef MDC_COMMUTATOR_FLUSH_EN
         drain_q <= drain_d;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_a     = out_a_q;
   assign bus.out_b     = out_b_q;
endmodule

// File: tb/tb_mdc_commutator.sv
// tb/tb_mdc_commutator.sv - self-checking bench for mdc_commutator at depth 4 and depth 1 driven in parallel.
module tb_mdc_commutator;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mdc_commutator_if #(.nb(16)) if4 ();
   mdc_commutator_if #(.nb(16)) if1 ();

   mdc_commutator #(.nb(16), .depth(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4.slave));
   mdc_commutator #(.nb(16), .depth(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));

   typedef struct {
      logic sof;
      int   a;
      int   b;
      logic v4;
      logic s4;
      int   ea4;
      int   eb4;
      logic v1;
      logic s1;
      int   ea1;
      int   eb1;
   } vec_t;

   vec_t tbl [16];
   int   ah [$];
   int   bh [$];

   function automatic vec_t mk(logic sof, int a, int b, logic v4, logic s4, int ea4, int eb4,
                               logic v1, logic s1, int ea1, int eb1);
      vec_t r;
      r.sof = sof; r.a = a; r.b = b;
      r.v4 = v4; r.s4 = s4; r.ea4 = ea4; r.eb4 = eb4;
      r.v1 = v1; r.s1 = s1; r.ea1 = ea1; r.eb1 = eb1;
      return r;
   endfunction

   // Pair formula: upper-path pairs in the second half of each 2D period, lower-path pairs in the first.
   function automatic void ref_pair(input int d, input int j, output int ea, output int eb);
      int k;
      k = j % (2 * d);
      if (k >= d) begin
         ea = ah[j-d];
         eb = ah[j];
      end else if (j >= 2 * d) begin
         ea = bh[j-2*d];
         eb = bh[j-d];
      end else begin
         ea = 0;
         eb = 0;
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk4(input string tag, input int v, input int s, input int a, input int b);
      chk({tag, " d4 out_valid"}, int'(if4.out_valid), v);
      chk({tag, " d4 out_sof"}, int'(if4.out_sof), s);
      chk({tag, " d4 out_a"}, int'(if4.out_a), a);
      chk({tag, " d4 out_b"}, int'(if4.out_b), b);
   endtask

   task automatic chk1(input string tag, input int v, input int s, input int a, input int b);
      chk({tag, " d1 out_valid"}, int'(if1.out_valid), v);
      chk({tag, " d1 out_sof"}, int'(if1.out_sof), s);
      chk({tag, " d1 out_a"}, int'(if1.out_a), a);
      chk({tag, " d1 out_b"}, int'(if1.out_b), b);
   endtask

   task automatic drive(input logic v, input logic s, input int a, input int b);
      if4.in_valid = v;      if1.in_valid = v;
      if4.in_sof   = s;      if1.in_sof   = s;
      if4.in_a     = 16'(a); if1.in_a     = 16'(a);
      if4.in_b     = 16'(b); if1.in_b     = 16'(b);
`ifdef MDC_COMMUTATOR_FLUSH_EN
      if4.in_flush = 1'b0;   if1.in_flush = 1'b0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int   j, f, ea, eb, l4a, l4b, l1a, l1b;
      logic v, s;
      int   a, b;

      tbl[0]  = mk(1,  0, 100, 0, 0,   0,   0, 0, 0,   0,   0);
      tbl[1]  = mk(0,  1, 101, 0, 0,   0,   0, 1, 1,   0,   1);
      tbl[2]  = mk(0,  2, 102, 0, 0,   0,   0, 1, 0, 100, 101);
      tbl[3]  = mk(0,  3, 103, 0, 0,   0,   0, 1, 0,   2,   3);
      tbl[4]  = mk(0,  4, 104, 1, 1,   0,   4, 1, 0, 102, 103);
      tbl[5]  = mk(0,  5, 105, 1, 0,   1,   5, 1, 0,   4,   5);
      tbl[6]  = mk(0,  6, 106, 1, 0,   2,   6, 1, 0, 104, 105);
      tbl[7]  = mk(0,  7, 107, 1, 0,   3,   7, 1, 0,   6,   7);
      tbl[8]  = mk(1,  8, 108, 1, 0, 100, 104, 1, 0, 106, 107);
      tbl[9]  = mk(0,  9, 109, 1, 0, 101, 105, 1, 1,   8,   9);
      tbl[10] = mk(0, 10, 110, 1, 0, 102, 106, 1, 0, 108, 109);
      tbl[11] = mk(0, 11, 111, 1, 0, 103, 107, 1, 0,  10,  11);
      tbl[12] = mk(0, 12, 112, 1, 1,   8,  12, 1, 0, 110, 111);
      tbl[13] = mk(0, 13, 113, 1, 0,   9,  13, 1, 0,  12,  13);
      tbl[14] = mk(0, 14, 114, 1, 0,  10,  14, 1, 0, 112, 113);
      tbl[15] = mk(0, 15, 115, 1, 0,  11,  15, 1, 0,  14,  15);

      // Table pass 0 streams continuously; pass 1 inserts an idle cycle after every sample.
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         chk4("reset", 0, 0, 0, 0);
         chk1("reset", 0, 0, 0, 0);
         for (int n = 0; n < 16; n++) begin
            drive(1'b1, tbl[n].sof, tbl[n].a, tbl[n].b);
            tick();
            chk4($sformatf("tbl p%0d n%0d", pass, n), tbl[n].v4, tbl[n].s4, tbl[n].ea4, tbl[n].eb4);
            chk1($sformatf("tbl p%0d n%0d", pass, n), tbl[n].v1, tbl[n].s1, tbl[n].ea1, tbl[n].eb1);
            if (pass == 1) begin
               drive(1'b0, 1'b0, 999, 999);
               tick();
               chk4($sformatf("gap n%0d", n), 0, 0, tbl[n].ea4, tbl[n].eb4);
               chk1($sformatf("gap n%0d", n), 0, 0, tbl[n].ea1, tbl[n].eb1);
            end
         end
      end

      // Pre-sof samples are ignored; reset mid-frame discards delay-line contents.
      do_reset();
      for (int n = 0; n < 3; n++) begin
         drive(1'b1, 1'b0, 50 + n, 60 + n);
         tick();
         chk4($sformatf("presof n%0d", n), 0, 0, 0, 0);
      end
      for (int n = 0; n < 7; n++) begin
         drive(1'b1, n == 0, n, 100 + n);
         tick();
      end
      chk4("pre-reset n6", 1, 0, 2, 6);
      rst = 1'b1;
      drive(1'b1, 1'b0, 7, 107);
      tick();
      rst = 1'b0;
      chk4("midreset", 0, 0, 0, 0);
      chk1("midreset", 0, 0, 0, 0);
      for (int n = 0; n < 5; n++) begin
         drive(1'b1, n == 0, 200 + n, 300 + n);
         tick();
         if (n < 4) chk4($sformatf("reprime n%0d", n), 0, 0, 0, 0);
         else       chk4("reprime n4", 1, 1, 200, 204);
      end

      // Randomized stream with gaps and frame-aligned in_sof, checked against the pair formula.
      do_reset();
      ah.delete();
      bh.delete();
      j = 0; f = 0;
      l4a = 0; l4b = 0; l1a = 0; l1b = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         v = ($urandom_range(0, 3) != 0);
         if (v) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            s = (j == 0) || ((j % 8 == 0) && ($urandom_range(0, 1) == 1));
            ah.push_back(a);
            bh.push_back(b);
            f = s ? 0 : f + 1;
            drive(1'b1, s, a, b);
            tick();
            ref_pair(4, j, l4a, l4b);
            chk4($sformatf("rnd j%0d", j), int'(j >= 4), int'(f == 4), l4a, l4b);
            ref_pair(1, j, l1a, l1b);
            chk1($sformatf("rnd j%0d", j), int'(j >= 1), int'(f == 1), l1a, l1b);
            j++;
         end else begin
            drive(1'b0, $urandom_range(0, 1) == 1, 12345, 54321);
            tick();
            chk4($sformatf("rnd gap c%0d", cyc), 0, 0, l4a, l4b);
            chk1($sformatf("rnd gap c%0d", cyc), 0, 0, l1a, l1b);
         end
      end

`ifdef MDC_COMMUTATOR_FLUSH_EN
      // Eight samples, then six bubbles: depth4 drains four lower-path pairs, depth1 drains one.
      do_reset();
      for (int n = 0; n < 8; n++) begin
         drive(1'b1, n == 0, n, 100 + n);
         tick();
         if (n >= 4) chk4($sformatf("flush pre n%0d", n), 1, int'(n == 4), n - 4, n);
      end
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b1, 77, 77);
         if4.in_flush = 1'b1;
         if1.in_flush = 1'b1;
         tick();
         chk($sformatf("flush d4 valid k%0d", k), int'(if4.out_valid), int'(k < 4));
         chk($sformatf("flush d4 sof k%0d", k), int'(if4.out_sof), 0);
         if (k < 4) begin
            chk($sformatf("flush d4 out_a k%0d", k), int'(if4.out_a), 100 + k);
            chk($sformatf("flush d4 out_b k%0d", k), int'(if4.out_b), 104 + k);
         end
         chk($sformatf("flush d1 valid k%0d", k), int'(if1.out_valid), int'(k < 1));
         if (k == 0) begin
            chk("flush d1 out_a k0", int'(if1.out_a), 106);
            chk("flush d1 out_b k0", int'(if1.out_b), 107);
         end
      end
      drive(1'b0, 1'b0, 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
